relu_maxpool_stage: RTL and testbench



---
 rtl/relu_maxpool_stage.sv | 135 +++++++++++++
 tb/tb_relu_maxpool_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage: ReLU followed by 2x2 / stride-2 signed max pooling over a raster sample stream.
// Define RELU_STAGE_RELU_EN to clamp negative samples to zero before pooling.
module relu_maxpool_stage #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] input1,
  output logic [7:0] output1,
  output logic       outValid,
  output logic       frameDone
);

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
    if ($signed(a) > $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  function automatic logic [7:0] preprocess(input logic [7:0] v);
`ifdef RELU_STAGE_RELU_EN
    return v[7] ? 8'd0 : v;
`else
    return v;
`endif
  endfunction

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [7:0]    pair_r;
  logic [7:0]    row_buf_r [HALF_W];
  logic [7:0]    out_r;
  logic          out_valid_r;
  logic          frame_done_r;

  logic [7:0]    x_s;
  logic [7:0]    pair_max_s;
  logic [7:0]    pool_s;
  logic [BW-1:0] buf_idx_s;
  logic [CW-1:0] col_next_s;
  logic [RW-1:0] row_next_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          buf_we_s;
  logic          emit_s;
  logic          frame_end_s;

  // Datapath maxima, raster position advance and write/emit decode
  always_comb begin
    x_s         = preprocess(input1);
    pair_max_s  = smax8(pair_r, x_s);
    buf_idx_s   = BW'(col_r >> 1);
    pool_s      = smax8(row_buf_r[buf_idx_s], pair_max_s);
    col_last_s  = (col_r == COL_LAST);
    row_last_s  = (row_r == ROW_LAST);
    col_next_s  = col_r;
    row_next_s  = row_r;
    if (col_last_s) begin
      col_next_s = {CW{1'b0}};
      if (row_last_s) begin
        row_next_s = {RW{1'b0}};
      end else begin
        row_next_s = row_r + RW'(1);
      end
    end else begin
      col_next_s = col_r + CW'(1);
      row_next_s = row_r;
    end
    // odd columns close a horizontal pair; row parity picks store vs. pool
    buf_we_s    = enable & col_r[0] & ~row_r[0];
    emit_s      = enable & col_r[0] & row_r[0];
    frame_end_s = emit_s & col_last_s & row_last_s;
  end

  // Raster counters and horizontal pair register
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r  <= {CW{1'b0}};
      row_r  <= {RW{1'b0}};
      pair_r <= 8'd0;
    end else if (enable) begin
      col_r <= col_next_s;
      row_r <= row_next_s;
      if (!col_r[0]) begin
        pair_r <= x_s;
      end else begin
        pair_r <= pair_r;
      end
    end else begin
      col_r  <= col_r;
      row_r  <= row_r;
      pair_r <= pair_r;
    end
  end

  // Row buffer of pair maxima; never reset because every entry is written on an even row before use
  always_ff @(posedge clk) begin
    if (!reset && buf_we_s) begin
      row_buf_r[buf_idx_s] <= pair_max_s;
    end
  end

  // Registered pooled output and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r        <= 8'd0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      out_valid_r  <= emit_s;
      frame_done_r <= frame_end_s;
      if (emit_s) begin
        out_r <= pool_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign output1   = out_r;
  assign outValid  = out_valid_r;
  assign frameDone = frame_done_r;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Scoreboard bench for relu_maxpool_stage: three instances (4x2, 2x2, 4x4) driven one at a time.
// Expected windows come from a full-frame reference model honouring RELU_STAGE_RELU_EN.
module tb_relu_maxpool_stage;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en   [3];
  logic [7:0] din  [3];
  logic [7:0] dout [3];
  logic       vld  [3];
  logic       fd   [3];

  int         checks;
  int         errors;
  int         stim [64];
  logic [7:0] last_exp [3];
  exp_t       exp_q [$];
  exp_t       mon_e;

  relu_maxpool_stage #(.IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .reset(reset), .enable(en[0]), .input1(din[0]),
    .output1(dout[0]), .outValid(vld[0]), .frameDone(fd[0]));

  relu_maxpool_stage #(.IMG_W(2), .IMG_H(2)) dut_b (
    .clk(clk), .reset(reset), .enable(en[1]), .input1(din[1]),
    .output1(dout[1]), .outValid(vld[1]), .frameDone(fd[1]));

  relu_maxpool_stage #(.IMG_W(4), .IMG_H(4)) dut_c (
    .clk(clk), .reset(reset), .enable(en[2]), .input1(din[2]),
    .output1(dout[2]), .outValid(vld[2]), .frameDone(fd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int relu_m(input int v);
`ifdef RELU_STAGE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drive n samples of stim into instance k, with gap stall cycles after each.
  task automatic play(input int k, input int w, input int h, input int n, input int gap);
    int   frm [64];
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int p, r, c, m;
      p = i % (w * h);
      r = p / w;
      c = p % w;
      @(posedge clk); #1;
      en[k]  = 1'b1;
      din[k] = 8'(stim[i]);
      frm[p] = relu_m(stim[i]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = max2(max2(frm[(r-1)*w + c-1], frm[(r-1)*w + c]),
                 max2(frm[r*w + c-1], frm[r*w + c]));
        e.id   = k;
        e.d    = 8'(m);
        e.last = (r == h - 1) && (c == w - 1);
        exp_q.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        en[k] = 1'b0;
      end
    end
    @(posedge clk); #1;
    en[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on outValid, otherwise checks hold/idle behaviour.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        last_exp[k] = 8'd0;
      end else if (vld[k]) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_instance", k, mon_e.id);
          check_eq("output1", int'(dout[k]), int'(mon_e.d));
          check_eq("frameDone", int'(fd[k]), int'(mon_e.last));
          last_exp[k] = mon_e.d;
        end
      end else begin
        check_eq("output1_hold", int'(dout[k]), int'(last_exp[k]));
        check_eq("frameDone_idle", int'(fd[k]), 0);
      end
    end
  end

  initial begin
    int t1 [8];
    int t2 [4];
    int want_b;
    checks = 0;
    errors = 0;
    t1 = '{3, -5, 10, 2, -1, 7, 4, 12};
    t2 = '{-3, -5, -8, -2};
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      din[k] = 8'd0;
    end
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_output1", int'(dout[k]), 0);
      check_eq("reset_outValid", int'(vld[k]), 0);
      check_eq("reset_frameDone", int'(fd[k]), 0);
    end

    // 4x2 frame, contiguous
    for (int i = 0; i < 8; i++) stim[i] = t1[i];
    play(0, 4, 2, 8, 0);
    idle(4);
    check_eq("a_final", int'(dout[0]), 12);

    // same frame with 3-cycle stalls between samples
    play(0, 4, 2, 8, 3);
    idle(4);

    // partial frame, reset mid-frame, then full replay
    play(0, 4, 2, 5, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    play(0, 4, 2, 8, 0);
    idle(4);

    // 2x2 all-negative window
    for (int i = 0; i < 4; i++) stim[i] = t2[i];
    play(1, 2, 2, 4, 0);
    idle(3);
`ifdef RELU_STAGE_RELU_EN
    want_b = 8'h00;
`else
    want_b = 8'hFE;
`endif
    check_eq("b_negative_window", int'(dout[1]), want_b);

    // 4x4, two back-to-back frames of 0..15
    for (int i = 0; i < 32; i++) stim[i] = i % 16;
    play(2, 4, 4, 32, 0);
    idle(4);
    check_eq("c_final", int'(dout[2]), 15);

    idle(4);
    check_eq("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
